uv_bus_arb_2x1: RTL and testbench



---
 rtl/uv_bus_arb_2x1.sv | 93 +++++++++
 tb/tb_uv_bus_arb_2x1.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uv_bus_arb_2x1.sv
// uv_bus_arb_2x1: round-robin 2-to-1 bus arbiter with in-order response routing
// Ports: clk/rst_n (sync, active-low); mst{0,1}_req_* request channel from each master;
// mst{0,1}_rsp_* response channel back to each master; slv_req_* muxed request to the
// slave; slv_rsp_* slave response, routed by the owner FIFO head.
module uv_bus_arb_2x1 #(
  parameter int ALEN = 32,
  parameter int DLEN = 32,
  parameter int MLEN = DLEN / 8,
  parameter int OUTS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mst0_req_vld,
  output logic            mst0_req_rdy,
  input  logic            mst0_req_read,
  input  logic [ALEN-1:0] mst0_req_addr,
  input  logic [MLEN-1:0] mst0_req_mask,
  input  logic [DLEN-1:0] mst0_req_data,
  output logic            mst0_rsp_vld,
  input  logic            mst0_rsp_rdy,
  output logic [1:0]      mst0_rsp_excp,
  output logic [DLEN-1:0] mst0_rsp_data,
  input  logic            mst1_req_vld,
  output logic            mst1_req_rdy,
  input  logic            mst1_req_read,
  input  logic [ALEN-1:0] mst1_req_addr,
  input  logic [MLEN-1:0] mst1_req_mask,
  input  logic [DLEN-1:0] mst1_req_data,
  output logic            mst1_rsp_vld,
  input  logic            mst1_rsp_rdy,
  output logic [1:0]      mst1_rsp_excp,
  output logic [DLEN-1:0] mst1_rsp_data,
  output logic            slv_req_vld,
  input  logic            slv_req_rdy,
  output logic            slv_req_read,
  output logic [ALEN-1:0] slv_req_addr,
  output logic [MLEN-1:0] slv_req_mask,
  output logic [DLEN-1:0] slv_req_data,
  input  logic            slv_rsp_vld,
  output logic            slv_rsp_rdy,
  input  logic [1:0]      slv_rsp_excp,
  input  logic [DLEN-1:0] slv_rsp_data
);
  localparam int PW = $clog2(OUTS_DEPTH);
  logic rr_ptr, lock, lock_id, grant, head, full, empty, accept, pop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [OUTS_DEPTH-1:0] owner;
  assign full = count == (PW+1)'(OUTS_DEPTH);
  assign empty = count == '0;
  // grant defaults to master0 when idle so the request fields show master0
  assign grant = lock ? lock_id : (mst0_req_vld && mst1_req_vld) ? rr_ptr : mst1_req_vld;
  assign slv_req_vld = (grant ? mst1_req_vld : mst0_req_vld) && !full;
  assign slv_req_read = grant ? mst1_req_read : mst0_req_read;
  assign slv_req_addr = grant ? mst1_req_addr : mst0_req_addr;
  assign slv_req_mask = grant ? mst1_req_mask : mst0_req_mask;
  assign slv_req_data = grant ? mst1_req_data : mst0_req_data;
  assign mst0_req_rdy = !grant && slv_req_rdy && !full && mst0_req_vld;
  assign mst1_req_rdy = grant && slv_req_rdy && !full && mst1_req_vld;
  assign accept = slv_req_vld && slv_req_rdy;
  assign head = owner[rd_ptr];
  assign slv_rsp_rdy = (head ? mst1_rsp_rdy : mst0_rsp_rdy) && !empty;
  assign mst0_rsp_vld = slv_rsp_vld && !empty && !head;
  assign mst1_rsp_vld = slv_rsp_vld && !empty && head;
  assign mst0_rsp_excp = slv_rsp_excp;
  assign mst1_rsp_excp = slv_rsp_excp;
  assign mst0_rsp_data = slv_rsp_data;
  assign mst1_rsp_data = slv_rsp_data;
  assign pop = slv_rsp_vld && slv_rsp_rdy;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
      lock <= 1'b0;
      lock_id <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        owner[wr_ptr] <= grant;
        wr_ptr <= wr_ptr + PW'(1);
        rr_ptr <= ~grant;
        lock <= 1'b0;
      end else if (slv_req_vld) begin
        // a stalled request must stay stable, so pin the grant until accepted
        lock <= 1'b1;
        lock_id <= grant;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(accept) - (PW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_uv_bus_arb_2x1.sv
// tb_uv_bus_arb_2x1: directed self-checking bench for uv_bus_arb_2x1
module tb_uv_bus_arb_2x1;
  logic clk = 0, rst_n = 0;
  logic mst0_req_vld, mst0_req_rdy, mst0_req_read, mst0_rsp_vld, mst0_rsp_rdy;
  logic mst1_req_vld, mst1_req_rdy, mst1_req_read, mst1_rsp_vld, mst1_rsp_rdy;
  logic [31:0] mst0_req_addr, mst0_req_data, mst0_rsp_data, mst1_req_addr, mst1_req_data, mst1_rsp_data;
  logic [3:0] mst0_req_mask, mst1_req_mask, slv_req_mask;
  logic [1:0] mst0_rsp_excp, mst1_rsp_excp, slv_rsp_excp;
  logic slv_req_vld, slv_req_rdy, slv_req_read, slv_rsp_vld, slv_rsp_rdy;
  logic [31:0] slv_req_addr, slv_req_data, slv_rsp_data;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  uv_bus_arb_2x1 dut (
    .clk(clk), .rst_n(rst_n),
    .mst0_req_vld(mst0_req_vld), .mst0_req_rdy(mst0_req_rdy), .mst0_req_read(mst0_req_read),
    .mst0_req_addr(mst0_req_addr), .mst0_req_mask(mst0_req_mask), .mst0_req_data(mst0_req_data),
    .mst0_rsp_vld(mst0_rsp_vld), .mst0_rsp_rdy(mst0_rsp_rdy), .mst0_rsp_excp(mst0_rsp_excp),
    .mst0_rsp_data(mst0_rsp_data),
    .mst1_req_vld(mst1_req_vld), .mst1_req_rdy(mst1_req_rdy), .mst1_req_read(mst1_req_read),
    .mst1_req_addr(mst1_req_addr), .mst1_req_mask(mst1_req_mask), .mst1_req_data(mst1_req_data),
    .mst1_rsp_vld(mst1_rsp_vld), .mst1_rsp_rdy(mst1_rsp_rdy), .mst1_rsp_excp(mst1_rsp_excp),
    .mst1_rsp_data(mst1_rsp_data),
    .slv_req_vld(slv_req_vld), .slv_req_rdy(slv_req_rdy), .slv_req_read(slv_req_read),
    .slv_req_addr(slv_req_addr), .slv_req_mask(slv_req_mask), .slv_req_data(slv_req_data),
    .slv_rsp_vld(slv_rsp_vld), .slv_rsp_rdy(slv_rsp_rdy), .slv_rsp_excp(slv_rsp_excp),
    .slv_rsp_data(slv_rsp_data)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 0;
    mst0_req_vld = 0; mst0_req_read = 1; mst0_req_addr = 0; mst0_req_mask = 4'hF; mst0_req_data = 0; mst0_rsp_rdy = 1;
    mst1_req_vld = 0; mst1_req_read = 1; mst1_req_addr = 0; mst1_req_mask = 4'hF; mst1_req_data = 0; mst1_rsp_rdy = 1;
    slv_req_rdy = 0; slv_rsp_vld = 0; slv_rsp_excp = 0; slv_rsp_data = 0;
    step;
    rst_n = 1;
  endtask
  task automatic test_reset;
    do_reset;
    #1;
    n_chk++; if (mst0_req_rdy !== 1'b0 || mst1_req_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_req_rdy: got %b%b exp 00", mst0_req_rdy, mst1_req_rdy); end
    n_chk++; if (slv_req_vld !== 1'b0 || slv_rsp_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_slv: got vld=%b rdy=%b exp 0 0", slv_req_vld, slv_rsp_rdy); end
    n_chk++; if (mst0_rsp_vld !== 1'b0 || mst1_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_vld: got %b%b exp 00", mst0_rsp_vld, mst1_rsp_vld); end
    n_chk++; if (dut.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", dut.count); end
  endtask
  task automatic test_single;
    do_reset;
    mst0_req_vld = 1; mst0_req_addr = 32'h100; slv_req_rdy = 1;
    #1;
    n_chk++; if (slv_req_vld !== 1'b1 || slv_req_addr !== 32'h100 || mst0_req_rdy !== 1'b1) begin n_fail++; $display("FAIL single_req0: got vld=%b addr=%h rdy=%b exp 1 100 1", slv_req_vld, slv_req_addr, mst0_req_rdy); end
    step;
    mst0_req_addr = 32'h104; slv_rsp_vld = 1; slv_rsp_data = 32'hA;
    #1;
    n_chk++; if (slv_req_addr !== 32'h104 || mst0_req_rdy !== 1'b1) begin n_fail++; $display("FAIL single_req1: got addr=%h rdy=%b exp 104 1", slv_req_addr, mst0_req_rdy); end
    n_chk++; if (mst0_rsp_vld !== 1'b1 || mst0_rsp_data !== 32'hA || mst1_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL single_rsp0: got vld0=%b data=%h vld1=%b exp 1 a 0", mst0_rsp_vld, mst0_rsp_data, mst1_rsp_vld); end
    step;
    mst0_req_vld = 0; slv_rsp_data = 32'hB;
    #1;
    n_chk++; if (mst0_rsp_vld !== 1'b1 || mst0_rsp_data !== 32'hB || mst1_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL single_rsp1: got vld0=%b data=%h vld1=%b exp 1 b 0", mst0_rsp_vld, mst0_rsp_data, mst1_rsp_vld); end
    step;
    slv_rsp_vld = 0;
    n_chk++; if (dut.count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d exp 0", dut.count); end
  endtask
  task automatic test_contention;
    logic [31:0] ea [4] = '{32'h200, 32'h300, 32'h200, 32'h300};
    do_reset;
    mst0_req_vld = 1; mst0_req_addr = 32'h200; mst1_req_vld = 1; mst1_req_addr = 32'h300; slv_req_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (slv_req_addr !== ea[i] || mst0_req_rdy !== (i % 2 == 0) || mst1_req_rdy !== (i % 2 == 1)) begin n_fail++; $display("FAIL contention_grant%0d: got addr=%h rdy=%b%b exp %h", i, slv_req_addr, mst0_req_rdy, mst1_req_rdy, ea[i]); end
      step;
    end
    mst0_req_vld = 0; mst1_req_vld = 0;
    n_chk++; if (dut.count !== 3'd4) begin n_fail++; $display("FAIL contention_count4: got %0d exp 4", dut.count); end
    slv_rsp_vld = 1;
    for (int i = 0; i < 4; i++) begin
      slv_rsp_data = i;
      #1;
      n_chk++; if (mst0_rsp_vld !== (i % 2 == 0) || mst1_rsp_vld !== (i % 2 == 1) || slv_rsp_rdy !== 1'b1) begin n_fail++; $display("FAIL contention_rsp%0d: got vld=%b%b rdy=%b", i, mst0_rsp_vld, mst1_rsp_vld, slv_rsp_rdy); end
      step;
    end
    slv_rsp_vld = 0;
    n_chk++; if (dut.count !== 3'd0) begin n_fail++; $display("FAIL contention_count0: got %0d exp 0", dut.count); end
  endtask
  task automatic test_stall;
    do_reset;
    mst0_req_vld = 1; mst0_req_addr = 32'h400; mst1_req_addr = 32'h500; slv_req_rdy = 1;
    step;
    slv_req_rdy = 0;
    step;
    mst1_req_vld = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (slv_req_addr !== 32'h400 || slv_req_vld !== 1'b1 || mst0_req_rdy !== 1'b0 || mst1_req_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got addr=%h vld=%b rdy=%b%b exp 400 1 00", i, slv_req_addr, slv_req_vld, mst0_req_rdy, mst1_req_rdy); end
      step;
    end
    slv_req_rdy = 1;
    #1;
    n_chk++; if (mst0_req_rdy !== 1'b1 || slv_req_addr !== 32'h400) begin n_fail++; $display("FAIL stall_accept: got rdy0=%b addr=%h exp 1 400", mst0_req_rdy, slv_req_addr); end
    step;
    n_chk++; if (slv_req_addr !== 32'h500 || mst1_req_rdy !== 1'b1) begin n_fail++; $display("FAIL stall_switch: got addr=%h rdy1=%b exp 500 1", slv_req_addr, mst1_req_rdy); end
  endtask
  task automatic test_full;
    do_reset;
    mst0_req_vld = 1; slv_req_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      mst0_req_addr = 32'h600 + 4 * i;
      #1;
      n_chk++; if (mst0_req_rdy !== 1'b1) begin n_fail++; $display("FAIL full_accept%0d: got rdy=%b exp 1", i, mst0_req_rdy); end
      step;
    end
    mst0_req_addr = 32'h610;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++; if (mst0_req_rdy !== 1'b0 || slv_req_vld !== 1'b0) begin n_fail++; $display("FAIL full_block%0d: got rdy=%b vld=%b exp 0 0", i, mst0_req_rdy, slv_req_vld); end
      step;
    end
    slv_rsp_vld = 1;
    #1;
    n_chk++; if (mst0_req_rdy !== 1'b0 || slv_rsp_rdy !== 1'b1) begin n_fail++; $display("FAIL full_pop_cycle: got req_rdy=%b rsp_rdy=%b exp 0 1", mst0_req_rdy, slv_rsp_rdy); end
    step;
    slv_rsp_vld = 0;
    n_chk++; if (mst0_req_rdy !== 1'b1 || dut.count !== 3'd3) begin n_fail++; $display("FAIL full_after_pop: got rdy=%b count=%0d exp 1 3", mst0_req_rdy, dut.count); end
    step;
    mst0_req_vld = 0;
    n_chk++; if (dut.count !== 3'd4) begin n_fail++; $display("FAIL full_refill: got %0d exp 4", dut.count); end
  endtask
  task automatic test_backpressure;
    do_reset;
    mst1_req_vld = 1; mst1_req_addr = 32'h700; slv_req_rdy = 1;
    step;
    mst1_req_vld = 0; mst1_rsp_rdy = 0; slv_rsp_vld = 1; slv_rsp_excp = 2'b01; slv_rsp_data = 32'hDEAD;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++; if (slv_rsp_rdy !== 1'b0 || mst1_rsp_vld !== 1'b1 || mst0_rsp_vld !== 1'b0 || mst1_rsp_excp !== 2'b01) begin n_fail++; $display("FAIL bp_hold%0d: got rdy=%b vld=%b%b excp=%b exp 0 01 01", i, slv_rsp_rdy, mst0_rsp_vld, mst1_rsp_vld, mst1_rsp_excp); end
      step;
    end
    n_chk++; if (dut.count !== 3'd1) begin n_fail++; $display("FAIL bp_count_held: got %0d exp 1", dut.count); end
    mst1_rsp_rdy = 1;
    #1;
    n_chk++; if (slv_rsp_rdy !== 1'b1 || mst1_rsp_excp !== 2'b01) begin n_fail++; $display("FAIL bp_release: got rdy=%b excp=%b exp 1 01", slv_rsp_rdy, mst1_rsp_excp); end
    step;
    slv_rsp_vld = 0;
    n_chk++; if (dut.count !== 3'd0) begin n_fail++; $display("FAIL bp_popped: got %0d exp 0", dut.count); end
  endtask
  task automatic test_mid_reset;
    do_reset;
    mst0_req_vld = 1; slv_req_rdy = 1;
    for (int i = 0; i < 3; i++) step;
    mst0_req_vld = 0;
    n_chk++; if (dut.count !== 3'd3) begin n_fail++; $display("FAIL midrst_pre: got %0d exp 3", dut.count); end
    rst_n = 0;
    step;
    rst_n = 1;
    n_chk++; if (dut.count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d exp 0", dut.count); end
    slv_rsp_vld = 1;
    #1;
    n_chk++; if (slv_rsp_rdy !== 1'b0 || mst0_rsp_vld !== 1'b0 || mst1_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_stray: got rdy=%b vld=%b%b exp 0 00", slv_rsp_rdy, mst0_rsp_vld, mst1_rsp_vld); end
    step;
    slv_rsp_vld = 0;
  endtask
  initial begin
    test_reset;
    test_single;
    test_contention;
    test_stall;
    test_full;
    test_backpressure;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
